stopwatch_lap_ctrl: RTL and testbench
=====================================

Name: stopwatch_lap_ctrl

Overview:
- Parametrised control FSM for the stopwatch datapath. It gates the time counter, issues store strobes for lap/split results into an external result RAM, and drives indexed review of the stored results.
- Generalises the fixed 10-result controller in three ways: configurable result depth, a pause mode, and clear/restart from view.
- Sits between the debounced key-pulse logic and the time counter / result RAM / display mux.

Parameters:
- MAX_LAPS, 10, number of result slots; legal range 2..256.
- IDX_W, $clog2(MAX_LAPS), width of slot indices (derived, do not override).
- CNT_W, $clog2(MAX_LAPS+1), width of the stored-result count (derived).
- SCROLL_TICKS, 4, tick pulses per auto-scroll step (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse: start / pause / resume.
- lap  in  1  single-cycle pulse: store a split, keep running.
- stop  in  1  single-cycle pulse: store the final result and enter view.
- next  in  1  single-cycle pulse: view the next slot.
- prev  in  1  single-cycle pulse: view the previous slot.
- clear  in  1  single-cycle pulse: discard all results and return to idle.
- tick  in  1  slow timebase strobe (optional feature only; ignored otherwise).
- enable  out  1  time counter run enable.
- store  out  1  one-cycle write strobe to the result RAM.
- store_idx  out  IDX_W  RAM write address, valid while store=1.
- rview  out  1  display shows a stored result rather than the live time.
- view_idx  out  IDX_W  RAM read address for the display.
- lap_count  out  CNT_W  number of valid stored results.
- full  out  1  lap_count == MAX_LAPS.

Behaviour:
- Reset:
  - Asynchronous assert on reset low; deassertion is synchronous to clk.
  - State IDLE; every output 0.
- Timing:
  - All outputs are registered.
  - An input pulse sampled at edge N is reflected on the outputs after edge N, i.e. one cycle of latency.
- States: IDLE, RUN, PAUSE, VIEW.
- Input priority within a cycle: clear > stop > lap > start. next and prev are evaluated only in VIEW.
- IDLE:
  - enable=0, rview=0.
  - start -> RUN with enable=1.
  - All other inputs are ignored.
- RUN:
  - enable=1.
  - lap with lap_count < MAX_LAPS-1: store=1, store_idx=lap_count, lap_count+1; stay in RUN.
  - lap with lap_count == MAX_LAPS-1: store to the last slot, lap_count=MAX_LAPS, go to VIEW. This is the automatic stop on the final slot.
  - stop: store at store_idx=lap_count, lap_count+1, go to VIEW.
  - start: go to PAUSE with enable=0.
- PAUSE:
  - enable=0.
  - start: go to RUN.
  - stop: store as in RUN, go to VIEW.
  - lap: ignored.
- VIEW:
  - enable=0, rview=1.
  - view_idx is loaded with 0 on entry.
  - next: view_idx+1, wrapping from lap_count-1 to 0.
  - prev: view_idx-1, wrapping from 0 to lap_count-1.
  - next and prev in the same cycle: no change.
  - lap_count==1: view_idx is held at 0.
  - start and lap: ignored.
- clear, from any state: go to IDLE. lap_count, view_idx, enable, rview all go to 0; store=0 that cycle. The external time counter reset is clear itself.
- Store rules:
  - store never asserts when full=1.
  - lap_count saturates at MAX_LAPS.
  - store_idx holds its last value while store=0.
- Arithmetic:
  - Index math is CNT_W-wide and truncated to IDX_W.
  - No wrap other than the explicit view wrap.
- Illegal state encoding: recover to IDLE on the next clock.

Optional Feature:
- Macro: STOPWATCH_AUTO_SCROLL_EN.
- Defined:
  - In VIEW, an internal counter counts tick pulses.
  - Every SCROLL_TICKS ticks, view_idx advances exactly as for next.
  - Any next or prev resets this counter to 0.
  - The counter is cleared on entry to VIEW and on reset.
- Undefined: tick is unused and there is no auto-advance; view_idx changes only on next/prev.

Test Plan:
- Reset low mid-RUN with lap_count=3 -> all outputs 0 immediately (asynchronous); after release, state IDLE and enable=0.
- MAX_LAPS=10: start, then lap x3, then stop -> store pulses at idx 0,1,2,3; lap_count=4; rview=1; view_idx=0; enable=0.
- MAX_LAPS=4: start, then lap x4 -> stores at idx 0..3, automatic entry to VIEW on the 4th lap, full=1.
- VIEW with lap_count=4: prev -> view_idx=3; next x2 -> 0 then 1; next and prev in the same cycle -> stays 1.
- RUN: start -> PAUSE, enable=0; lap ignored (no store); start -> enable=1. Then lap and stop in the same cycle -> single store, VIEW entered.
- VIEW: clear -> IDLE with lap_count=0 and rview=0. With STOPWATCH_AUTO_SCROLL_EN, SCROLL_TICKS=4, lap_count=3: 12 tick pulses -> view_idx sequence 1, 2, 0.

Source files
------------

// File: rtl/stopwatch_lap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_lap_ctrl
// Description : Stopwatch control FSM. Gates the time counter, strobes lap and
//               split results into a result RAM and drives indexed review.
//               Optional auto-scroll in VIEW: STOPWATCH_AUTO_SCROLL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_lap_ctrl #(
    parameter int MAX_LAPS     = 10,
    parameter int IDX_W        = $clog2(MAX_LAPS),
    parameter int CNT_W        = $clog2(MAX_LAPS + 1),
    parameter int SCROLL_TICKS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             lap,
    input  logic             stop,
    input  logic             next,
    input  logic             prev,
    input  logic             clear,
    input  logic             tick,
    output logic             enable,
    output logic             store,
    output logic [IDX_W-1:0] store_idx,
    output logic             rview,
    output logic [IDX_W-1:0] view_idx,
    output logic [CNT_W-1:0] lap_count,
    output logic             full
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_VIEW  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_max_laps = CNT_W'(MAX_LAPS);
    localparam logic [CNT_W-1:0] c_last     = CNT_W'(MAX_LAPS - 1);

    state_t           r_state;
    state_t           w_state_nx;
    logic             w_store_nx;
    logic [IDX_W-1:0] w_store_idx_nx;
    logic [IDX_W-1:0] w_view_idx_nx;
    logic [CNT_W-1:0] w_lap_count_nx;
    logic [CNT_W-1:0] w_view_ext;
    logic [IDX_W-1:0] w_view_inc;
    logic [IDX_W-1:0] w_view_dec;
    logic             w_scroll_step;

    // Wrapping neighbours of the current view slot; a single result pins to 0.
    assign w_view_ext = CNT_W'(view_idx);
    assign w_view_inc = ((lap_count <= c_one) || (w_view_ext >= (lap_count - c_one)))
                        ? '0 : IDX_W'(w_view_ext + c_one);
    assign w_view_dec = (lap_count <= c_one) ? '0
                        : (view_idx == '0) ? IDX_W'(lap_count - c_one)
                        : (view_idx - IDX_W'(1));

    always_comb begin
        w_state_nx     = r_state;
        w_store_nx     = 1'b0;
        w_store_idx_nx = store_idx;
        w_view_idx_nx  = view_idx;
        w_lap_count_nx = lap_count;

        if (clear) begin
            w_state_nx     = S_IDLE;
            w_view_idx_nx  = '0;
            w_lap_count_nx = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_state_nx = S_RUN;
                    end
                end
                S_RUN, S_PAUSE: begin
                    if (stop || (lap && (r_state == S_RUN))) begin
                        if (!full) begin
                            w_store_nx     = 1'b1;
                            w_store_idx_nx = IDX_W'(lap_count);
                            w_lap_count_nx = lap_count + c_one;
                        end
                        // A lap into the final slot doubles as an automatic stop.
                        if (stop || (lap_count >= c_last)) begin
                            w_state_nx    = S_VIEW;
                            w_view_idx_nx = '0;
                        end
                    end else if (start) begin
                        w_state_nx = (r_state == S_RUN) ? S_PAUSE : S_RUN;
                    end
                end
                S_VIEW: begin
                    if (next && !prev) begin
                        w_view_idx_nx = w_view_inc;
                    end else if (prev && !next) begin
                        w_view_idx_nx = w_view_dec;
                    end else if (w_scroll_step) begin
                        w_view_idx_nx = w_view_inc;
                    end
                end
                default: begin
                    w_state_nx     = S_IDLE;
                    w_view_idx_nx  = '0;
                    w_lap_count_nx = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            enable    <= 1'b0;
            store     <= 1'b0;
            store_idx <= '0;
            rview     <= 1'b0;
            view_idx  <= '0;
            lap_count <= '0;
            full      <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            enable    <= (w_state_nx == S_RUN);
            store     <= w_store_nx;
            store_idx <= w_store_idx_nx;
            rview     <= (w_state_nx == S_VIEW);
            view_idx  <= w_view_idx_nx;
            lap_count <= w_lap_count_nx;
            full      <= (w_lap_count_nx == c_max_laps);
        end
    end

`ifdef STOPWATCH_AUTO_SCROLL_EN
    localparam int c_scr_w = (SCROLL_TICKS > 1) ? $clog2(SCROLL_TICKS) : 1;
    localparam logic [c_scr_w-1:0] c_scr_last = c_scr_w'(SCROLL_TICKS - 1);

    logic [c_scr_w-1:0] r_scroll_cnt;
    logic [c_scr_w-1:0] w_scroll_cnt_nx;

    // Held at zero outside VIEW, so every VIEW entry starts a fresh interval.
    always_comb begin
        w_scroll_cnt_nx = r_scroll_cnt;
        w_scroll_step   = 1'b0;
        if ((r_state != S_VIEW) || clear || next || prev) begin
            w_scroll_cnt_nx = '0;
        end else if (tick) begin
            if (r_scroll_cnt == c_scr_last) begin
                w_scroll_cnt_nx = '0;
                w_scroll_step   = 1'b1;
            end else begin
                w_scroll_cnt_nx = r_scroll_cnt + c_scr_w'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_scroll_cnt <= '0;
        end else begin
            r_scroll_cnt <= w_scroll_cnt_nx;
        end
    end
`else
    logic w_unused_tick;
    assign w_unused_tick = tick & (SCROLL_TICKS > 0);
    assign w_scroll_step = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_lap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_stopwatch_lap_ctrl
// Description : Scoreboard bench for stopwatch_lap_ctrl, MAX_LAPS=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_lap_ctrl;

    localparam logic [6:0] K_NONE  = 7'd0;
    localparam logic [6:0] K_START = 7'd1;
    localparam logic [6:0] K_LAP   = 7'd2;
    localparam logic [6:0] K_STOP  = 7'd4;
    localparam logic [6:0] K_NEXT  = 7'd8;
    localparam logic [6:0] K_PREV  = 7'd16;
    localparam logic [6:0] K_CLEAR = 7'd32;
    localparam logic [6:0] K_TICK  = 7'd64;

    typedef struct packed {
        logic       en;
        logic       st;
        logic [1:0] sidx;
        logic       rv;
        logic [1:0] vidx;
        logic [2:0] cnt;
        logic       fl;
    } out_t;

    typedef struct {
        out_t  v;
        string name;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0, lap = 1'b0, stop = 1'b0, next = 1'b0;
    logic       prev = 1'b0, clear = 1'b0, tick = 1'b0;
    logic       enable, store, rview, full;
    logic [1:0] store_idx, view_idx;
    logic [2:0] lap_count;

    exp_t expq[$];
    int   n_cmp = 0;
    int   n_err = 0;

    stopwatch_lap_ctrl #(.MAX_LAPS(4), .SCROLL_TICKS(4)) dut (
        .clk(clk), .reset(reset), .start(start), .lap(lap), .stop(stop),
        .next(next), .prev(prev), .clear(clear), .tick(tick),
        .enable(enable), .store(store), .store_idx(store_idx), .rview(rview),
        .view_idx(view_idx), .lap_count(lap_count), .full(full)
    );

    always #5 clk = ~clk;

    function automatic out_t got_v();
        return {enable, store, store_idx, rview, view_idx, lap_count, full};
    endfunction

    function automatic void compare(string nm, out_t g, out_t e);
        n_cmp++;
        if (g !== e) begin
            n_err++;
            $display("FAIL %s: got en=%0b st=%0b sidx=%0d rv=%0b vidx=%0d cnt=%0d full=%0b, expected en=%0b st=%0b sidx=%0d rv=%0b vidx=%0d cnt=%0d full=%0b",
                     nm, g.en, g.st, g.sidx, g.rv, g.vidx, g.cnt, g.fl,
                     e.en, e.st, e.sidx, e.rv, e.vidx, e.cnt, e.fl);
        end
    endfunction

    // Monitor: outputs registered at a rising edge are checked 1 time unit later.
    always @(posedge clk) begin
        #1;
        if (expq.size() > 0) begin
            exp_t e;
            e = expq.pop_front();
            compare(e.name, got_v(), e.v);
        end
    end

    task automatic drive(input logic [6:0] k);
        {tick, clear, prev, next, stop, lap, start} = k;
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the edge.
    task automatic cyc(input string nm, input logic [6:0] k,
                       input logic en, input logic st, input logic [1:0] sidx,
                       input logic rv, input logic [1:0] vidx,
                       input logic [2:0] cnt, input logic fl);
        exp_t e;
        @(negedge clk);
        drive(k);
        e.v    = {en, st, sidx, rv, vidx, cnt, fl};
        e.name = nm;
        expq.push_back(e);
    endtask

    initial begin
        #2 reset = 1'b0;
        #1 compare("reset_init", got_v(), '0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Three laps then stop
        cyc("a_start", K_START, 1, 0, 0, 0, 0, 0, 0);
        cyc("a_lap0",  K_LAP,   1, 1, 0, 0, 0, 1, 0);
        cyc("a_lap1",  K_LAP,   1, 1, 1, 0, 0, 2, 0);
        cyc("a_lap2",  K_LAP,   1, 1, 2, 0, 0, 3, 0);
        cyc("a_stop",  K_STOP,  0, 1, 3, 1, 0, 4, 1);
        cyc("a_hold",  K_NONE,  0, 0, 3, 1, 0, 4, 1);
        cyc("a_prev",  K_PREV,  0, 0, 3, 1, 3, 4, 1);
        cyc("a_next1", K_NEXT,  0, 0, 3, 1, 0, 4, 1);
        cyc("a_next2", K_NEXT,  0, 0, 3, 1, 1, 4, 1);
        cyc("a_both",  K_NEXT | K_PREV, 0, 0, 3, 1, 1, 4, 1);
        cyc("a_vstart", K_START, 0, 0, 3, 1, 1, 4, 1);
        cyc("a_vlap",  K_LAP,   0, 0, 3, 1, 1, 4, 1);
        cyc("a_clear", K_CLEAR, 0, 0, 3, 0, 0, 0, 0);

        // Fourth lap fills the last slot and stops automatically
        cyc("b_start", K_START, 1, 0, 3, 0, 0, 0, 0);
        cyc("b_lap0",  K_LAP,   1, 1, 0, 0, 0, 1, 0);
        cyc("b_lap1",  K_LAP,   1, 1, 1, 0, 0, 2, 0);
        cyc("b_lap2",  K_LAP,   1, 1, 2, 0, 0, 3, 0);
        cyc("b_lap3",  K_LAP,   0, 1, 3, 1, 0, 4, 1);
        cyc("b_next",  K_NEXT,  0, 0, 3, 1, 1, 4, 1);
        cyc("b_fulllap", K_LAP | K_STOP, 0, 0, 3, 1, 1, 4, 1);
        cyc("b_clear", K_CLEAR, 0, 0, 3, 0, 0, 0, 0);

        // Pause / resume, then lap and stop together
        cyc("c_start",  K_START, 1, 0, 3, 0, 0, 0, 0);
        cyc("c_pause",  K_START, 0, 0, 3, 0, 0, 0, 0);
        cyc("c_plap",   K_LAP,   0, 0, 3, 0, 0, 0, 0);
        cyc("c_resume", K_START, 1, 0, 3, 0, 0, 0, 0);
        cyc("c_lapstop", K_LAP | K_STOP, 0, 1, 0, 1, 0, 1, 0);
        cyc("c_next1",  K_NEXT,  0, 0, 0, 1, 0, 1, 0);
        cyc("c_prev1",  K_PREV,  0, 0, 0, 1, 0, 1, 0);
        cyc("c_clrstop", K_CLEAR | K_STOP, 0, 0, 0, 0, 0, 0, 0);
        cyc("c_ilap",   K_LAP,   0, 0, 0, 0, 0, 0, 0);
        cyc("c_istop",  K_STOP,  0, 0, 0, 0, 0, 0, 0);
        cyc("c_inext",  K_NEXT,  0, 0, 0, 0, 0, 0, 0);

        // Stop from PAUSE, wrap with two results
        cyc("d_start", K_START, 1, 0, 0, 0, 0, 0, 0);
        cyc("d_lap",   K_LAP,   1, 1, 0, 0, 0, 1, 0);
        cyc("d_pause", K_START, 0, 0, 0, 0, 0, 1, 0);
        cyc("d_stop",  K_STOP,  0, 1, 1, 1, 0, 2, 0);
        cyc("d_next1", K_NEXT,  0, 0, 1, 1, 1, 2, 0);
        cyc("d_next2", K_NEXT,  0, 0, 1, 1, 0, 2, 0);
        cyc("d_prev",  K_PREV,  0, 0, 1, 1, 1, 2, 0);
        cyc("d_clear", K_CLEAR, 0, 0, 1, 0, 0, 0, 0);

        // Three results in VIEW, then tick pulses
        cyc("e_start", K_START, 1, 0, 1, 0, 0, 0, 0);
        cyc("e_lap0",  K_LAP,   1, 1, 0, 0, 0, 1, 0);
        cyc("e_lap1",  K_LAP,   1, 1, 1, 0, 0, 2, 0);
        cyc("e_stop",  K_STOP,  0, 1, 2, 1, 0, 3, 0);
`ifdef STOPWATCH_AUTO_SCROLL_EN
        for (int k = 1; k <= 12; k++) begin
            cyc($sformatf("e_tick%0d", k), K_TICK, 0, 0, 2, 1, 2'((k / 4) % 3), 3, 0);
        end
        cyc("e_tick13", K_TICK, 0, 0, 2, 1, 0, 3, 0);
        cyc("e_tick14", K_TICK, 0, 0, 2, 1, 0, 3, 0);
        cyc("e_nextrst", K_NEXT, 0, 0, 2, 1, 1, 3, 0);
        for (int k = 1; k <= 3; k++) begin
            cyc($sformatf("e_post%0d", k), K_TICK, 0, 0, 2, 1, 1, 3, 0);
        end
        cyc("e_post4", K_TICK, 0, 0, 2, 1, 2, 3, 0);
`else
        for (int k = 1; k <= 5; k++) begin
            cyc($sformatf("e_tick%0d", k), K_TICK, 0, 0, 2, 1, 0, 3, 0);
        end
`endif
        cyc("e_clear", K_CLEAR, 0, 0, 2, 0, 0, 0, 0);

        // Asynchronous reset in RUN with three results stored
        cyc("f_start", K_START, 1, 0, 2, 0, 0, 0, 0);
        cyc("f_lap0",  K_LAP,   1, 1, 0, 0, 0, 1, 0);
        cyc("f_lap1",  K_LAP,   1, 1, 1, 0, 0, 2, 0);
        cyc("f_lap2",  K_LAP,   1, 1, 2, 0, 0, 3, 0);
        @(negedge clk);
        drive(K_NONE);
        #2 reset = 1'b0;
        #1 compare("reset_async", got_v(), '0);
        @(negedge clk);
        reset = 1'b1;
        cyc("f_idle",  K_NONE,  0, 0, 0, 0, 0, 0, 0);
        cyc("f_start2", K_START, 1, 0, 0, 0, 0, 0, 0);

        @(negedge clk);
        drive(K_NONE);
        for (int i = 0; i < 10 && expq.size() > 0; i++) @(negedge clk);
        if (expq.size() > 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expectations, expected 0", expq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout at %0t, expected completion", $time);
        $fatal(1);
    end

endmodule
`default_nettype wire
